// File: rtl/restador_serial.sv
// -----------------------------------------------------------------------------
// restador_serial
//
// Bit-serial N-bit subtractor: D = A - B - Bi, processed LSB first, one bit per
// clock, through a single registered full-subtractor cell. The design trades
// area for latency: an operation takes N clock cycles from the accepting edge.
//
// Handshake:
//   - start is sampled only while idle. The accepting edge latches A, B and Bi.
//   - busy stays high for the N cycles of the operation.
//   - done pulses for one cycle, the same cycle in which D/Bo first show the
//     new result.
//   - start in the done cycle is accepted, so operations can run back to back.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset; aborts any operation in progress
//   start  operation request (ignored while busy)
//   A      minuend, N bits
//   B      subtrahend, N bits
//   Bi     borrow-in
//   D      difference, N bits, registered, updated only at completion
//   Bo     final borrow-out, registered, updated only at completion
//   busy   high while an operation is in progress
//   done   one-cycle completion pulse
//
// Parameters:
//   N      operand/result width, N >= 1
// -----------------------------------------------------------------------------
module restador_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bi,
  output logic [N-1:0] D,
  output logic         Bo,
  output logic         busy,
  output logic         done
);

  // The counter must be able to hold the values 0..N-1 for every legal N.
  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_next;

  logic [N-1:0]    sa, sa_next;     // minuend shift register
  logic [N-1:0]    sb, sb_next;     // subtrahend shift register
  logic [N-1:0]    sd, sd_next;     // partial result, filled from the MSB
  logic            br, br_next;     // running borrow
  logic [CW-1:0]   cnt, cnt_next;   // bits already processed
  logic [N-1:0]    d_next;
  logic            bo_next;
  logic            done_next;

  // Full-subtractor cell operating on the current LSBs.
  logic            bit_a, bit_b;
  logic            bit_d;
  logic            bit_br;
  logic [N-1:0]    sd_shift;
  logic            last_bit;

  assign bit_a  = sa[0];
  assign bit_b  = sb[0];
  assign bit_d  = bit_a ^ bit_b ^ br;
  assign bit_br = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);

  // New difference bit enters at the MSB while older bits move toward the LSB.
  // Shifting the (N+1)-bit concatenation keeps the expression valid for N = 1,
  // where the partial result has no bits left to retain.
  assign sd_shift = N'({bit_d, sd} >> 1);

  // The N-th processed bit is the one seen while the counter reads N-1.
  assign last_bit = (cnt == CW'(N - 1));

  assign busy = (state == RUN);

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its hold value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    sa_next    = sa;
    sb_next    = sb;
    sd_next    = sd;
    br_next    = br;
    cnt_next   = cnt;
    d_next     = D;
    bo_next    = Bo;
    done_next  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          sa_next    = A;
          sb_next    = B;
          br_next    = Bi;
          cnt_next   = '0;
          sd_next    = '0;
        end
      end

      RUN: begin
        sa_next  = sa >> 1;
        sb_next  = sb >> 1;
        br_next  = bit_br;
        sd_next  = sd_shift;
        cnt_next = cnt + CW'(1);
        if (last_bit) begin
          // Final bit: publish the completed word and the outgoing borrow.
          state_next = IDLE;
          d_next     = sd_shift;
          bo_next    = bit_br;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments make every register sample the values that
  // existed before the edge, so the order of the statements does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the working registers are cleared as well as the outputs, so an
      // aborted operation leaves no partial result or stale borrow behind.
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      Bo    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      sa    <= sa_next;
      sb    <= sb_next;
      sd    <= sd_next;
      br    <= br_next;
      cnt   <= cnt_next;
      D     <= d_next;
      Bo    <= bo_next;
      done  <= done_next;
    end
  end

endmodule

// File: tb/tb_restador_serial.sv
// -----------------------------------------------------------------------------
// tb_restador_serial
//
// Self-checking bench for restador_serial. Two instances are exercised: an
// 8-bit build (directed cases, then random operations) and a 1-bit build
// (random operations). Expected results come from plain integer arithmetic
// on the operands; expected timing comes from the handshake rules (N busy
// cycles, then one done cycle with the new result).
// -----------------------------------------------------------------------------
module tb_restador_serial;

  localparam int N  = 8;
  localparam int N1 = 1;

  logic          clk = 1'b0;
  logic          rst;

  // 8-bit instance
  logic          start;
  logic [N-1:0]  a, b;
  logic          bi;
  logic [N-1:0]  d;
  logic          bo, busy, done;

  // 1-bit instance
  logic          start1;
  logic [N1-1:0] a1, b1;
  logic          bi1;
  logic [N1-1:0] d1;
  logic          bo1, busy1, done1;

  int total = 0;
  int bad   = 0;

  // Last result each instance should be holding.
  logic [N-1:0]  last_d;
  logic          last_bo;
  logic [N1-1:0] last_d1;
  logic          last_bo1;

  restador_serial #(.N(N)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Bi    (bi),
    .D     (d),
    .Bo    (bo),
    .busy  (busy),
    .done  (done)
  );

  restador_serial #(.N(N1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .A     (a1),
    .B     (b1),
    .Bi    (bi1),
    .D     (d1),
    .Bo    (bo1),
    .busy  (busy1),
    .done  (done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One operation on the 8-bit instance, entered at a negedge while idle.
  // keep   : leave start high for the whole operation
  // inject : pulse start with other operands during RUN cycle 3
  // Returns at the negedge of the done cycle.
  task automatic run8(input logic [N-1:0] ia, input logic [N-1:0] ib,
                      input logic ibi, input bit keep, input bit inject);
    int diff;
    diff    = int'(ia) - int'(ib) - int'(ibi);
    last_d  = N'(diff);
    last_bo = (diff < 0);
    start = 1'b1;
    a     = ia;
    b     = ib;
    bi    = ibi;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (!keep) start = 1'b0;
      a  = N'($urandom);
      b  = N'($urandom);
      bi = 1'($urandom);
      if (inject && i == 2) begin
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h10;
      end
      if (inject && i == 3) start = 1'b0;
      check("busy_run", busy, 1);
      check("done_run", done, 0);
    end
    @(negedge clk);
    check("busy_done", busy, 0);
    check("done_pulse", done, 1);
    check("d_result", d, last_d);
    check("bo_result", bo, last_bo);
  endtask

  task automatic idle8(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("busy_idle", busy, 0);
      check("done_idle", done, 0);
      check("d_hold", d, last_d);
      check("bo_hold", bo, last_bo);
    end
  endtask

  task automatic run1(input logic [N1-1:0] ia, input logic [N1-1:0] ib,
                      input logic ibi, input bit keep);
    int diff;
    diff     = int'(ia) - int'(ib) - int'(ibi);
    last_d1  = N1'(diff);
    last_bo1 = (diff < 0);
    start1 = 1'b1;
    a1     = ia;
    b1     = ib;
    bi1    = ibi;
    @(negedge clk);
    if (!keep) start1 = 1'b0;
    a1  = N1'($urandom);
    b1  = N1'($urandom);
    bi1 = 1'($urandom);
    check("n1_busy_run", busy1, 1);
    check("n1_done_run", done1, 0);
    @(negedge clk);
    check("n1_busy_done", busy1, 0);
    check("n1_done_pulse", done1, 1);
    check("n1_d_result", d1, last_d1);
    check("n1_bo_result", bo1, last_bo1);
  endtask

  task automatic idle1(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("n1_busy_idle", busy1, 0);
      check("n1_done_idle", done1, 0);
      check("n1_d_hold", d1, last_d1);
      check("n1_bo_hold", bo1, last_bo1);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bi     = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    bi1    = 1'b0;
    last_d   = '0;
    last_bo  = 1'b0;
    last_d1  = '0;
    last_bo1 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_d", d, 0);
    check("rst_bo", bo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("n1_rst_d", d1, 0);
    check("n1_rst_busy", busy1, 0);
    rst = 1'b0;
    idle8(2);

    // Basic subtraction, then the result must hold while idle
    run8(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
    idle8(3);

    // Negative result, borrow-in only, equal operands (back to back)
    run8(8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
    run8(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    run8(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    idle8(2);

    // A start pulse during RUN must be ignored
    run8(8'h80, 8'h01, 1'b0, 1'b0, 1'b1);
    idle8(2);

    // start held high: busy drops only in the done cycle
    run8(8'h0A, 8'h04, 1'b0, 1'b1, 1'b0);
    run8(8'h0A, 8'h04, 1'b0, 1'b1, 1'b0);
    run8(8'h0A, 8'h04, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    idle8(1);

    // Reset during RUN cycle 4 aborts the operation without a done pulse
    start = 1'b1;
    a     = 8'h55;
    b     = 8'h11;
    bi    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("abort_busy", busy, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_d  = '0;
    last_bo = 1'b0;
    check("abort_d", d, 0);
    check("abort_bo", bo, 0);
    check("abort_busy_low", busy, 0);
    check("abort_done", done, 0);
    idle8(N + 2);
    run8(8'h20, 8'h01, 1'b0, 1'b0, 1'b0);
    idle8(1);

    // Random operations, 8-bit build
    for (int k = 0; k < 1000; k++) begin
      bit keep;
      keep = ($urandom_range(0, 3) == 0);
      run8(N'($urandom), N'($urandom), 1'($urandom), keep, 1'b0);
      start = 1'b0;
      idle8($urandom_range(0, 2));
    end
    start = 1'b0;
    idle8(1);

    // Random operations, 1-bit build
    for (int k = 0; k < 1000; k++) begin
      bit keep;
      keep = ($urandom_range(0, 3) == 0);
      run1(N1'($urandom), N1'($urandom), 1'($urandom), keep);
      start1 = 1'b0;
      idle1($urandom_range(0, 2));
    end
    start1 = 1'b0;
    idle1(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
